cpeta_error_monitor: RTL and testbench
======================================

Name: cpeta_error_monitor

Overview:
- Sequential response-side checker for the CPETA approximate adder (N=16, K=9 build). It is the consumer at the far end of the stimulus path.
- Accepts (A, B, approximate sum) triples through a valid/ready handshake. Computes the exact (N+1)-bit sum and the error distance (ED).
- Accumulates error statistics over a programmable window of samples. Used on FPGA/in-sim to characterise adder accuracy without a software scoreboard.

Parameters:
- N, 16, operand and approximate-sum width
- K, 9, CPETA split point; informational, reported on k_id output
- CNT_W, 32, width of sample and error counters
- ACC_W, 48, width of the ED accumulator

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a new window and clears all statistics
- win_len  in  CNT_W  samples per window; sampled on start; 0 is treated as 1
- in_valid  in  1  sample valid
- in_ready  out  1  monitor can accept a sample
- a  in  N  operand A
- b  in  N  operand B
- approx_sum  in  N  CPETA output (carry-out dropped)
- busy  out  1  window in progress
- done  out  1  one-cycle pulse when window results are final
- sample_cnt  out  CNT_W  accepted samples in window
- err_cnt  out  CNT_W  samples with ED != 0
- ed_sum  out  ACC_W  sum of ED over window
- ed_max  out  N+1  maximum ED seen
- k_id  out  8  constant K

Behaviour:
- Reset: state IDLE. in_ready=0, busy=0, done=0, all statistics 0. k_id is constant.
- Handshake: a transfer occurs when in_valid && in_ready. in_ready=1 only in COLLECT while accepted < win_len_latched. in_valid is ignored otherwise.
- Arithmetic:
  - exact = a + b, computed at N+1 bits.
  - ED = |exact − {1'b0, approx_sum}|, N+1 bits unsigned.
  - Example: a=FFFF, b=0001, approx 0000 gives ED 0x10000.
- Pipeline:
  - Stage 1 registers exact and ED. Stage 2 updates the statistics.
  - A sample accepted at edge t is reflected in the outputs after edge t+2.
  - Full throughput: one sample per cycle.
- FSM:
  - IDLE: on start → COLLECT; latch win_len; clear stats.
  - COLLECT: accept samples. When the accepted count reaches win_len_latched → DRAIN.
  - DRAIN: wait 2 cycles for the pipeline to empty → DONE.
  - DONE: done=1 for exactly one cycle → IDLE. Stats are held until the next start.
  - busy=1 in COLLECT and DRAIN.
- start while busy aborts the current window: pipeline contents are discarded, stats are cleared, and COLLECT restarts with the new win_len. No done is produced for the aborted window.
- start in the DONE cycle: done still pulses, then the new window begins next cycle.
- Saturation:
  - sample_cnt, err_cnt and ed_sum saturate at all-ones; they never wrap.
  - ed_max updates only on a strictly greater ED.
- Asynchronous reset mid-window: everything returns to reset values immediately, with no done.

Optional Feature:
- Macro: CPETA_ED_HIST_EN.
- When defined, four extra outputs (CNT_W each, saturating) give an ED histogram:
  - hist0: ED in 1..15
  - hist1: ED in 16..255
  - hist2: ED in 256..4095
  - hist3: ED ≥ 4096
- Histogram counters clear on start and reset, and update in stage 2.
- When undefined, the ports and logic are absent. All other behaviour is identical.

Decomposition:
- Package cpeta_mon_pkg holds:
  - state enum: IDLE, COLLECT, DRAIN, DONE
  - default widths
  - histogram bin edge constants
- One sub-module: cpeta_ed_calc. It is combinational exact-sum/ED logic registered as stage 1, reusable by other adder monitors.

Test Plan:
1. Reset, then start with win_len=1; send a=1234, b=5678, approx=68AC → done after 3 cycles; sample_cnt=1, err_cnt=0, ed_sum=0, ed_max=0.
2. win_len=2; send (FFFF, 0001, 0000) then (AAAA, 5555, FFFF) → err_cnt=1, ed_sum=0x10000, ed_max=0x10000.
3. win_len=4 with in_valid toggling every other cycle → exactly 4 transfers counted; in_ready drops after the 4th transfer; done pulses once.
4. Mid-window start after 2 of 5 samples → no done for the aborted window; the new window reports only its own samples.
5. Force approx_sum=0 with a=b=8000 for 2^CNT_W-scale runs (backdoor preload of the counter near max) → sample_cnt holds at all-ones with no wrap.
6. With CPETA_ED_HIST_EN defined, send EDs 5, 100, 1000, 5000 → hist0..hist3 each equal 1.

Source files
------------

// File: rtl/cpeta_mon_pkg.sv
// cpeta_mon_pkg
// Shared definitions for the CPETA error monitor: FSM state encoding,
// default widths and the ED histogram bin edges.
// Optional feature macro: CPETA_ED_HIST_EN (histogram bins use the edges below).
package cpeta_mon_pkg;

    localparam int N_DEF     = 16;
    localparam int K_DEF     = 9;
    localparam int CNT_W_DEF = 32;
    localparam int ACC_W_DEF = 48;

    // Histogram bins: [1, EDGE1), [EDGE1, EDGE2), [EDGE2, EDGE3), [EDGE3, inf)
    localparam int HIST_EDGE1 = 16;
    localparam int HIST_EDGE2 = 256;
    localparam int HIST_EDGE3 = 4096;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } mon_state_t;

endpackage

// File: rtl/cpeta_ed_calc.sv
// cpeta_ed_calc
// Stage 1 of the error monitor: computes the exact (N+1)-bit sum a+b and the
// error distance ED = |exact - approx| and registers both with a valid flag.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   flush            drops whatever is in the stage (window restart)
//   fire             a sample is transferred this cycle
//   a, b, approx     operands and approximate sum (N bits each)
//   out_valid        stage holds a sample
//   exact, ed        registered exact sum and error distance (N+1 bits)
module cpeta_ed_calc #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         fire,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] approx,
    output logic         out_valid,
    output logic [N:0]   exact,
    output logic [N:0]   ed
);

    logic [N:0]   exact_c;
    logic [N+1:0] diff_c;
    logic [N+1:0] diff_neg_c;
    logic [N:0]   ed_c;

    // The difference spans -(2^N-1)..(2^(N+1)-2), so one extra sign bit is
    // needed; the magnitude always fits back into N+1 bits.
    always_comb begin
        exact_c    = {1'b0, a} + {1'b0, b};
        diff_c     = {1'b0, exact_c} - {2'b00, approx};
        diff_neg_c = ~diff_c + {{(N+1){1'b0}}, 1'b1};
        ed_c       = diff_c[N+1] ? diff_neg_c[N:0] : diff_c[N:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            exact     <= '0;
            ed        <= '0;
        end else begin
            out_valid <= fire && !flush;
            if (fire && !flush) begin
                exact <= exact_c;
                ed    <= ed_c;
            end
        end
    end

endmodule

// File: rtl/cpeta_error_monitor.sv
// cpeta_error_monitor
// Response-side accuracy checker for the CPETA approximate adder. Accepts
// (a, b, approx_sum) samples over valid/ready, computes the error distance
// and accumulates saturating statistics over a window of win_len samples.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 pulse: clear stats, latch win_len, open a window
//   win_len               samples per window (0 behaves as 1)
//   in_valid / in_ready   sample handshake
//   a, b, approx_sum      sample payload
//   busy, done            window in progress / one-cycle completion pulse
//   sample_cnt, err_cnt   accepted samples / samples with ED != 0
//   ed_sum, ed_max        sum and maximum of ED over the window
//   k_id                  constant split point K
//   hist0..hist3          ED histogram (only with CPETA_ED_HIST_EN defined)
//   state_dbg             current FSM state
// Handshake: a transfer happens on a rising edge where in_valid && in_ready;
// in_ready depends only on monitor state and start, never on in_valid, and
// in_valid is ignored whenever in_ready is low.
// Optional feature macro: CPETA_ED_HIST_EN.
module cpeta_error_monitor
    import cpeta_mon_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int K     = K_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] win_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    input  logic [N-1:0]     approx_sum,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [ACC_W-1:0] ed_sum,
    output logic [N:0]       ed_max,
    output logic [7:0]       k_id,
`ifdef CPETA_ED_HIST_EN
    output logic [CNT_W-1:0] hist0,
    output logic [CNT_W-1:0] hist1,
    output logic [CNT_W-1:0] hist2,
    output logic [CNT_W-1:0] hist3,
`endif
    output logic [1:0]       state_dbg
);

    mon_state_t       state, state_nxt;
    logic [CNT_W-1:0] win_q;
    logic [CNT_W-1:0] acc_cnt;
    logic             drain_cnt;
    logic             fire;
    logic             last_fire;

    logic             s1_valid;
    logic [N:0]       s1_exact;
    logic [N:0]       s1_ed;

    logic [CNT_W-1:0] sample_cnt_r;
    logic [CNT_W-1:0] err_cnt_r;
    logic [ACC_W-1:0] ed_sum_r;
    logic [N:0]       ed_max_r;
    logic [ACC_W:0]   ed_sum_add;

    // The exact sum is kept in stage 1 for other monitors reusing the
    // sub-module; the statistics here only need ED.
    logic unused_exact;
    assign unused_exact = ^s1_exact;

    // A start cycle never accepts: the sample would belong to no window.
    assign in_ready  = (state == COLLECT) && (acc_cnt < win_q) && !start;
    assign fire      = in_valid && in_ready;
    assign last_fire = fire && ((acc_cnt + CNT_W'(1)) == win_q);
    assign k_id      = 8'(K);
    assign state_dbg = state;

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: ;
            COLLECT: begin
                busy = 1'b1;
                if (last_fire) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (drain_cnt) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // start wins from any state; in DONE the pulse above still goes out.
        if (start) state_nxt = COLLECT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            win_q     <= '0;
            acc_cnt   <= '0;
            drain_cnt <= 1'b0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= (state == DRAIN) && !drain_cnt && !start;
            if (start) begin
                win_q   <= (win_len == '0) ? CNT_W'(1) : win_len;
                acc_cnt <= '0;
            end else if (fire) begin
                acc_cnt <= acc_cnt + CNT_W'(1);
            end
        end
    end

    cpeta_ed_calc #(.N(N)) u_ed_calc (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (start),
        .fire      (fire),
        .a         (a),
        .b         (b),
        .approx    (approx_sum),
        .out_valid (s1_valid),
        .exact     (s1_exact),
        .ed        (s1_ed)
    );

    assign ed_sum_add = {1'b0, ed_sum_r} + (ACC_W+1)'(s1_ed);

    // Stage 2: saturating statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt_r <= '0;
            err_cnt_r    <= '0;
            ed_sum_r     <= '0;
            ed_max_r     <= '0;
        end else if (start) begin
            sample_cnt_r <= '0;
            err_cnt_r    <= '0;
            ed_sum_r     <= '0;
            ed_max_r     <= '0;
        end else if (s1_valid) begin
            if (sample_cnt_r != '1) sample_cnt_r <= sample_cnt_r + CNT_W'(1);
            if (s1_ed != '0 && err_cnt_r != '1) err_cnt_r <= err_cnt_r + CNT_W'(1);
            ed_sum_r <= ed_sum_add[ACC_W] ? '1 : ed_sum_add[ACC_W-1:0];
            if (s1_ed > ed_max_r) ed_max_r <= s1_ed;
        end
    end

    assign sample_cnt = sample_cnt_r;
    assign err_cnt    = err_cnt_r;
    assign ed_sum     = ed_sum_r;
    assign ed_max     = ed_max_r;

`ifdef CPETA_ED_HIST_EN
    logic [CNT_W-1:0] hist_r [4];
    logic [1:0]       bin;

    always_comb begin
        bin = 2'd3;
        if (s1_ed < (N+1)'(HIST_EDGE1))      bin = 2'd0;
        else if (s1_ed < (N+1)'(HIST_EDGE2)) bin = 2'd1;
        else if (s1_ed < (N+1)'(HIST_EDGE3)) bin = 2'd2;
    end

    // ED == 0 falls into no bin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) hist_r[i] <= '0;
        end else if (start) begin
            for (int i = 0; i < 4; i++) hist_r[i] <= '0;
        end else if (s1_valid && s1_ed != '0 && hist_r[bin] != '1) begin
            hist_r[bin] <= hist_r[bin] + CNT_W'(1);
        end
    end

    assign hist0 = hist_r[0];
    assign hist1 = hist_r[1];
    assign hist2 = hist_r[2];
    assign hist3 = hist_r[3];
`endif

endmodule

// File: tb/tb_cpeta_error_monitor.sv
// tb_cpeta_error_monitor
// Self-checking bench for cpeta_error_monitor. Stats are predicted from a
// queue of ED values computed with plain integer arithmetic from each
// observed transfer. Define CPETA_ED_HIST_EN to also check the histogram.
module tb_cpeta_error_monitor;
    import cpeta_mon_pkg::*;

    localparam int N     = 16;
    localparam int CNT_W = 32;
    localparam int ACC_W = 48;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [CNT_W-1:0] win_len;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     a, b, approx_sum;
    logic             busy, done;
    logic [CNT_W-1:0] sample_cnt, err_cnt;
    logic [ACC_W-1:0] ed_sum;
    logic [N:0]       ed_max;
    logic [7:0]       k_id;
    logic [1:0]       state_dbg;
`ifdef CPETA_ED_HIST_EN
    logic [CNT_W-1:0] hist0, hist1, hist2, hist3;
`endif

    int checks = 0;
    int fails  = 0;
    int done_pulses = 0;
    logic [N:0] exp_q[$];

    logic [CNT_W-1:0] e_cnt, e_err;
    logic [ACC_W-1:0] e_sum;
    logic [N:0]       e_max;

    cpeta_error_monitor dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .win_len    (win_len),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .approx_sum (approx_sum),
        .busy       (busy),
        .done       (done),
        .sample_cnt (sample_cnt),
        .err_cnt    (err_cnt),
        .ed_sum     (ed_sum),
        .ed_max     (ed_max),
        .k_id       (k_id),
`ifdef CPETA_ED_HIST_EN
        .hist0      (hist0),
        .hist1      (hist1),
        .hist2      (hist2),
        .hist3      (hist3),
`endif
        .state_dbg  (state_dbg)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [N:0] model_ed(input logic [N-1:0] av, bv, sv);
        int s, d;
        s = int'(av) + int'(bv);
        d = s - int'(sv);
        if (d < 0) d = -d;
        return (N+1)'(d);
    endfunction

    task automatic model_stats();
        longint unsigned sum;
        e_cnt = '0; e_err = '0; e_max = '0; sum = 0;
        foreach (exp_q[i]) begin
            e_cnt = e_cnt + 1;
            if (exp_q[i] != 0) e_err = e_err + 1;
            sum = sum + exp_q[i];
            if (exp_q[i] > e_max) e_max = exp_q[i];
        end
        e_sum = ACC_W'(sum);
    endtask

    // Scoreboard feed: every observed transfer pushes its expected ED.
    always @(negedge clk) begin
        if (!rst_n) exp_q.delete();
        else begin
            if (start) exp_q.delete();
            else if (in_valid && in_ready) exp_q.push_back(model_ed(a, b, approx_sum));
            if (done) done_pulses++;
        end
    end

    // ---------------- drivers ----------------
    // Drivers run aligned 1 time unit after a rising edge.
    task automatic do_start(input logic [CNT_W-1:0] len);
        @(posedge clk); #1;
        start = 1'b1; win_len = len;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [N-1:0] av, bv, sv);
        int n;
        n = 0;
        in_valid = 1'b1; a = av; b = bv; approx_sum = sv;
        @(negedge clk);
        while (!in_ready && n < 40) begin @(negedge clk); n++; end
        checks++;
        if (!in_ready) begin
            fails++;
            $display("FAIL send_ready: in_ready=%0b after %0d cycles, required 1", in_ready, n);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Returns at the falling edge where done is seen; lat = falling edges waited.
    task automatic wait_done(input int bound, output int lat);
        lat = 0;
        for (int i = 1; i <= bound && lat == 0; i++) begin
            @(negedge clk);
            if (done) lat = i;
        end
        checks++;
        if (lat == 0) begin
            fails++;
            $display("FAIL done_timeout: no done within %0d cycles", bound);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks += 9;
        if (in_ready !== 1'b0)  begin fails++; $display("FAIL rst_in_ready: got %0b want 0", in_ready); end
        if (busy !== 1'b0)      begin fails++; $display("FAIL rst_busy: got %0b want 0", busy); end
        if (done !== 1'b0)      begin fails++; $display("FAIL rst_done: got %0b want 0", done); end
        if (sample_cnt !== '0)  begin fails++; $display("FAIL rst_sample_cnt: got %0h want 0", sample_cnt); end
        if (err_cnt !== '0)     begin fails++; $display("FAIL rst_err_cnt: got %0h want 0", err_cnt); end
        if (ed_sum !== '0)      begin fails++; $display("FAIL rst_ed_sum: got %0h want 0", ed_sum); end
        if (ed_max !== '0)      begin fails++; $display("FAIL rst_ed_max: got %0h want 0", ed_max); end
        if (k_id !== 8'd9)      begin fails++; $display("FAIL rst_k_id: got %0d want 9", k_id); end
        if (state_dbg !== IDLE) begin fails++; $display("FAIL rst_state: got %0d want %0d", state_dbg, IDLE); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        int lat;
        do_start(1);
        send(16'h1234, 16'h5678, 16'h68AC);
        wait_done(10, lat);
        checks += 5;
        if (lat != 3)          begin fails++; $display("FAIL single_latency: got %0d want 3", lat); end
        if (sample_cnt !== 1)  begin fails++; $display("FAIL single_sample_cnt: got %0h want 1", sample_cnt); end
        if (err_cnt !== 0)     begin fails++; $display("FAIL single_err_cnt: got %0h want 0", err_cnt); end
        if (ed_sum !== 0)      begin fails++; $display("FAIL single_ed_sum: got %0h want 0", ed_sum); end
        if (ed_max !== 0)      begin fails++; $display("FAIL single_ed_max: got %0h want 0", ed_max); end
        @(negedge clk);
        checks += 3;
        if (done !== 1'b0)     begin fails++; $display("FAIL single_done_width: got %0b want 0", done); end
        if (busy !== 1'b0)     begin fails++; $display("FAIL single_busy_after: got %0b want 0", busy); end
        if (sample_cnt !== 1)  begin fails++; $display("FAIL single_hold: got %0h want 1", sample_cnt); end
    endtask

    task automatic test_carry_error();
        int lat;
        do_start(2);
        send(16'hFFFF, 16'h0001, 16'h0000);
        send(16'hAAAA, 16'h5555, 16'hFFFF);
        wait_done(10, lat);
        checks += 4;
        if (sample_cnt !== 2)        begin fails++; $display("FAIL carry_sample_cnt: got %0h want 2", sample_cnt); end
        if (err_cnt !== 1)           begin fails++; $display("FAIL carry_err_cnt: got %0h want 1", err_cnt); end
        if (ed_sum !== 48'h10000)    begin fails++; $display("FAIL carry_ed_sum: got %0h want 10000", ed_sum); end
        if (ed_max !== 17'h10000)    begin fails++; $display("FAIL carry_ed_max: got %0h want 10000", ed_max); end
    endtask

    task automatic test_toggle_valid();
        int d0;
        do_start(4);
        d0 = done_pulses;
        for (int i = 0; i < 12; i++) begin
            in_valid = (i % 2 == 0); a = N'($urandom); b = N'($urandom); approx_sum = N'($urandom);
            @(negedge clk);
            if (i == 7) begin
                checks++;
                if (in_ready !== 1'b0) begin fails++; $display("FAIL toggle_ready_drop: got %0b want 0", in_ready); end
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        model_stats();
        checks += 6;
        if (exp_q.size() != 4)        begin fails++; $display("FAIL toggle_transfers: got %0d want 4", exp_q.size()); end
        if (done_pulses - d0 != 1)    begin fails++; $display("FAIL toggle_done_count: got %0d want 1", done_pulses - d0); end
        if (sample_cnt !== 4)         begin fails++; $display("FAIL toggle_sample_cnt: got %0h want 4", sample_cnt); end
        if (err_cnt !== e_err)        begin fails++; $display("FAIL toggle_err_cnt: got %0h want %0h", err_cnt, e_err); end
        if (ed_sum !== e_sum)         begin fails++; $display("FAIL toggle_ed_sum: got %0h want %0h", ed_sum, e_sum); end
        if (ed_max !== e_max)         begin fails++; $display("FAIL toggle_ed_max: got %0h want %0h", ed_max, e_max); end
    endtask

    task automatic test_abort();
        int lat, d0;
        do_start(5);
        d0 = done_pulses;
        send(16'h8000, 16'h8000, 16'h0000);
        send(16'h0100, 16'h0001, 16'h0000);
        do_start(3);
        for (int i = 0; i < 3; i++) send(16'h0010, N'(i), N'($urandom_range(0, 40)));
        wait_done(10, lat);
        model_stats();
        checks += 4;
        if (sample_cnt !== 3)   begin fails++; $display("FAIL abort_sample_cnt: got %0h want 3", sample_cnt); end
        if (err_cnt !== e_err)  begin fails++; $display("FAIL abort_err_cnt: got %0h want %0h", err_cnt, e_err); end
        if (ed_sum !== e_sum)   begin fails++; $display("FAIL abort_ed_sum: got %0h want %0h", ed_sum, e_sum); end
        if (ed_max !== e_max)   begin fails++; $display("FAIL abort_ed_max: got %0h want %0h", ed_max, e_max); end
        @(negedge clk);
        checks++;
        if (done_pulses - d0 != 1) begin fails++; $display("FAIL abort_done_count: got %0d want 1", done_pulses - d0); end
    endtask

    task automatic test_saturation();
        int lat;
        do_start(4);
        // Backdoor preload so a short window crosses the counter limits.
        dut.sample_cnt_r = 32'hFFFF_FFFE;
        dut.err_cnt_r    = 32'hFFFF_FFFE;
        dut.ed_sum_r     = 48'hFFFF_FFFE_8000;
        for (int i = 0; i < 4; i++) send(16'h8000, 16'h8000, 16'h0000);
        wait_done(10, lat);
        checks += 4;
        if (sample_cnt !== 32'hFFFF_FFFF)   begin fails++; $display("FAIL sat_sample_cnt: got %0h want ffffffff", sample_cnt); end
        if (err_cnt !== 32'hFFFF_FFFF)      begin fails++; $display("FAIL sat_err_cnt: got %0h want ffffffff", err_cnt); end
        if (ed_sum !== 48'hFFFF_FFFF_FFFF)  begin fails++; $display("FAIL sat_ed_sum: got %0h want ffffffffffff", ed_sum); end
        if (ed_max !== 17'h10000)           begin fails++; $display("FAIL sat_ed_max: got %0h want 10000", ed_max); end
    endtask

    task automatic test_random_windows();
        int lat, len, nsend;
        logic [N:0]   s;
        logic [N-1:0] av, bv, sv;
        for (int w = 0; w < 6; w++) begin
            len = (w == 0) ? 0 : $urandom_range(1, 12);
            nsend = (len == 0) ? 1 : len;
            do_start(CNT_W'(len));
            for (int i = 0; i < nsend; i++) begin
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                av = N'($urandom); bv = N'($urandom); s = {1'b0, av} + {1'b0, bv};
                case ($urandom_range(0, 3))
                    0: sv = s[N-1:0];
                    1: sv = s[N-1:0] + N'($urandom_range(0, 20));
                    2: sv = s[N-1:0] - N'($urandom_range(0, 3000));
                    default: sv = N'($urandom);
                endcase
                send(av, bv, sv);
            end
            wait_done(10, lat);
            model_stats();
            checks += 2;
            if (sample_cnt !== CNT_W'(nsend)) begin
                fails++; $display("FAIL rand_sample_cnt w%0d: got %0h want %0h", w, sample_cnt, nsend);
            end
            if ({err_cnt, ed_sum, ed_max} !== {e_err, e_sum, e_max}) begin
                fails++;
                $display("FAIL rand_stats w%0d: got err=%0h sum=%0h max=%0h want err=%0h sum=%0h max=%0h",
                         w, err_cnt, ed_sum, ed_max, e_err, e_sum, e_max);
            end
        end
    endtask

    task automatic test_async_reset();
        int d0;
        do_start(6);
        send(16'h0001, 16'h0001, 16'h0000);
        send(16'h0002, 16'h0002, 16'h0000);
        #2;
        rst_n = 1'b0;
        #1;
        checks += 4;
        if (busy !== 1'b0)       begin fails++; $display("FAIL arst_busy: got %0b want 0", busy); end
        if (in_ready !== 1'b0)   begin fails++; $display("FAIL arst_in_ready: got %0b want 0", in_ready); end
        if (sample_cnt !== '0)   begin fails++; $display("FAIL arst_sample_cnt: got %0h want 0", sample_cnt); end
        if (state_dbg !== IDLE)  begin fails++; $display("FAIL arst_state: got %0d want %0d", state_dbg, IDLE); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        d0 = done_pulses;
        repeat (6) @(negedge clk);
        checks += 2;
        if (done_pulses != d0)   begin fails++; $display("FAIL arst_no_done: got %0d pulses want 0", done_pulses - d0); end
        if (busy !== 1'b0)       begin fails++; $display("FAIL arst_idle: busy %0b want 0", busy); end
    endtask

`ifdef CPETA_ED_HIST_EN
    task automatic test_histogram();
        int lat;
        do_start(4);
        send(16'h1000, 16'h0000, 16'h1000 - 16'd5);
        send(16'h1000, 16'h0000, 16'h1000 - 16'd100);
        send(16'h1000, 16'h0000, 16'h1000 - 16'd1000);
        send(16'h2000, 16'h0000, 16'h2000 - 16'd5000);
        wait_done(10, lat);
        checks += 4;
        if (hist0 !== 1) begin fails++; $display("FAIL hist0: got %0h want 1", hist0); end
        if (hist1 !== 1) begin fails++; $display("FAIL hist1: got %0h want 1", hist1); end
        if (hist2 !== 1) begin fails++; $display("FAIL hist2: got %0h want 1", hist2); end
        if (hist3 !== 1) begin fails++; $display("FAIL hist3: got %0h want 1", hist3); end
    endtask
`endif

    // ---------------- sequence + report ----------------
    initial begin
        rst_n = 1'b0; start = 1'b0; win_len = '0; in_valid = 1'b0;
        a = '0; b = '0; approx_sum = '0;
        test_reset();
        test_single();
        test_carry_error();
        test_toggle_valid();
        test_abort();
        test_saturation();
        test_random_windows();
        test_async_reset();
`ifdef CPETA_ED_HIST_EN
        test_histogram();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
